control_sequencer: RTL

- Micro-step controller for the 8-bit bus CPU. It generates the write-assert (wa) and output-assert (oa) strobes for the program counter, MAR, RAM, IR, A, B, ALU and output registers.
- Every bus register in the design, including each gpr instance, is driven by this block.
- It runs a fixed fetch sequence followed by an opcode-dependent execute sequence, stepping through T-states T1..T6.

---
 rtl/cpu_ctrl_pkg.sv | 42 ++++
 rtl/t_state_ring.sv | 36 +++
 rtl/control_sequencer.sv | 129 ++++++++++++
 3 files changed

// File: rtl/cpu_ctrl_pkg.sv
// ------------------------------------------------------------------
// cpu_ctrl_pkg : opcodes, T-state encodings, control-word bit map
// Rev 1.0
// ------------------------------------------------------------------
`default_nettype none
package cpu_ctrl_pkg;

  localparam logic [3:0] OP_LDA = 4'h0;
  localparam logic [3:0] OP_ADD = 4'h1;
  localparam logic [3:0] OP_SUB = 4'h2;
  localparam logic [3:0] OP_JMP = 4'h3;
  localparam logic [3:0] OP_OUT = 4'hE;
  localparam logic [3:0] OP_HLT = 4'hF;

  // One-hot T-states; HALT is all-zero so it doubles as the debug t_state value.
  typedef enum logic [5:0] {
    ST_HALT = 6'b000000,
    ST_T1   = 6'b000001,
    ST_T2   = 6'b000010,
    ST_T3   = 6'b000100,
    ST_T4   = 6'b001000,
    ST_T5   = 6'b010000,
    ST_T6   = 6'b100000
  } t_state_e;

  localparam int CW_PC_INC = 0;
  localparam int CW_PC_OA  = 1;
  localparam int CW_PC_WA  = 2;
  localparam int CW_MAR_WA = 3;
  localparam int CW_RAM_OA = 4;
  localparam int CW_IR_WA  = 5;
  localparam int CW_IR_OA  = 6;
  localparam int CW_A_WA   = 7;
  localparam int CW_A_OA   = 8;
  localparam int CW_B_WA   = 9;
  localparam int CW_ALU_OA = 10;
  localparam int CW_SUB    = 11;
  localparam int CW_OUT_WA = 12;
  localparam int CW_W      = 13;

endpackage
`default_nettype wire

// File: rtl/t_state_ring.sv
// ------------------------------------------------------------------
// t_state_ring : one-hot T1..T6 ring counter with restart and HALT
// Rev 1.0
// ------------------------------------------------------------------
`default_nettype none
module t_state_ring
  import cpu_ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       clr,
  input  logic       run,
  input  logic       restart,
  input  logic       halt_req,
  output logic [5:0] t_state
);

  t_state_e state, next;

  always_ff @(posedge clk or posedge clr) begin
    if (clr) state <= ST_T1;
    else     state <= next;
  end

  always_comb begin
    next = state;
    if (run && (state != ST_HALT)) begin
      if (halt_req)                         next = ST_HALT;
      else if (restart || (state == ST_T6)) next = ST_T1;
      else                                  next = t_state_e'({state[4:0], 1'b0});
    end
  end

  assign t_state = state;

endmodule
`default_nettype wire

// File: rtl/control_sequencer.sv
// ------------------------------------------------------------------
// control_sequencer : fetch/execute strobe decode for the 8-bit bus CPU
// Rev 1.0
// ------------------------------------------------------------------
`default_nettype none
module control_sequencer
  import cpu_ctrl_pkg::*;
#(
  parameter int OPW         = 4,
  parameter int SHORT_CYCLE = 1
) (
  input  logic           clk,
  input  logic           clr,
  input  logic           run,
  input  logic [OPW-1:0] ir_opcode,
  output logic           pc_inc,
  output logic           pc_oa,
  output logic           pc_wa,
  output logic           mar_wa,
  output logic           ram_oa,
  output logic           ir_wa,
  output logic           ir_oa,
  output logic           a_wa,
  output logic           a_oa,
  output logic           b_wa,
  output logic           alu_oa,
  output logic           sub,
  output logic           out_wa,
  output logic           halt,
  output logic [5:0]     t_state
);

  logic [CW_W-1:0] cw;
  logic [CW_W-1:0] strobes;
  logic            last_step;
  logic            restart;
  logic            halt_req;
  logic            is_lda, is_add, is_sub, is_jmp, is_out, is_hlt, is_nop;

  assign is_lda = (ir_opcode == OPW'(OP_LDA));
  assign is_add = (ir_opcode == OPW'(OP_ADD));
  assign is_sub = (ir_opcode == OPW'(OP_SUB));
  assign is_jmp = (ir_opcode == OPW'(OP_JMP));
  assign is_out = (ir_opcode == OPW'(OP_OUT));
  assign is_hlt = (ir_opcode == OPW'(OP_HLT));
  assign is_nop = ~(is_lda | is_add | is_sub | is_jmp | is_out | is_hlt);

  t_state_ring u_ring (
    .clk      (clk),
    .clr      (clr),
    .run      (run),
    .restart  (restart),
    .halt_req (halt_req),
    .t_state  (t_state)
  );

  always_comb begin
    cw        = '0;
    last_step = 1'b0;
    case (t_state)
      ST_T1: begin
        cw[CW_PC_OA]  = 1'b1;
        cw[CW_MAR_WA] = 1'b1;
      end
      ST_T2: cw[CW_PC_INC] = 1'b1;
      ST_T3: begin
        cw[CW_RAM_OA] = 1'b1;
        cw[CW_IR_WA]  = 1'b1;
        last_step     = is_nop;
      end
      ST_T4: begin
        if (is_lda || is_add || is_sub) begin
          cw[CW_IR_OA]  = 1'b1;
          cw[CW_MAR_WA] = 1'b1;
        end else if (is_jmp) begin
          cw[CW_IR_OA]  = 1'b1;
          cw[CW_PC_WA]  = 1'b1;
        end else if (is_out) begin
          cw[CW_A_OA]   = 1'b1;
          cw[CW_OUT_WA] = 1'b1;
        end
        last_step = is_jmp | is_out | is_hlt;
      end
      ST_T5: begin
        if (is_lda) begin
          cw[CW_RAM_OA] = 1'b1;
          cw[CW_A_WA]   = 1'b1;
        end else if (is_add || is_sub) begin
          cw[CW_RAM_OA] = 1'b1;
          cw[CW_B_WA]   = 1'b1;
          cw[CW_SUB]    = is_sub;
        end
        last_step = is_lda;
      end
      ST_T6: begin
        if (is_add || is_sub) begin
          cw[CW_ALU_OA] = 1'b1;
          cw[CW_A_WA]   = 1'b1;
          cw[CW_SUB]    = is_sub;
        end
        last_step = 1'b1;
      end
      default: ;
    endcase
  end

  assign restart  = (SHORT_CYCLE != 0) && last_step;
  assign halt_req = (t_state == ST_T4) && is_hlt;

  // Gating on run keeps a held write strobe from firing on every stalled cycle.
  assign strobes = (run && !clr) ? cw : '0;
  assign halt    = (t_state == ST_HALT) && !clr;

  assign pc_inc = strobes[CW_PC_INC];
  assign pc_oa  = strobes[CW_PC_OA];
  assign pc_wa  = strobes[CW_PC_WA];
  assign mar_wa = strobes[CW_MAR_WA];
  assign ram_oa = strobes[CW_RAM_OA];
  assign ir_wa  = strobes[CW_IR_WA];
  assign ir_oa  = strobes[CW_IR_OA];
  assign a_wa   = strobes[CW_A_WA];
  assign a_oa   = strobes[CW_A_OA];
  assign b_wa   = strobes[CW_B_WA];
  assign alu_oa = strobes[CW_ALU_OA];
  assign sub    = strobes[CW_SUB];
  assign out_wa = strobes[CW_OUT_WA];

endmodule
`default_nettype wire
